ils_decode_monitor: RTL and testbench
=====================================

ILS_DECODE_MONITOR -- requirements
Module: ils_decode_monitor

Interface
REQ-001 The parameter list SHALL be: CNT_W, default 16, width of each class counter.
REQ-002 The port list SHALL begin with: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The port list SHALL continue with: reset_n  input  1  synchronous, active-low reset.
REQ-004 The input ports SHALL be: in_valid  input  1  instruction offered; in_instr  input  32  RV32 instruction word.
REQ-005 The output port in_ready  output  1 SHALL mean that the block can accept an instruction this cycle.
REQ-006 The downstream ports SHALL be: out_ready  input  1  consumer accepts head entry; out_valid  output  1  head entry valid.
REQ-007 The decoded-entry outputs SHALL be: out_class  output  2  0=ALUI, 1=LOAD, 2=STORE, 3=ILLEGAL; out_rd, out_rs1, out_rs2  output  5 each; out_funct3  output  3; out_imm  output  32.
REQ-008 The output port out_load_use  output  1 SHALL mean that the entry reads the rd of the immediately preceding accepted load.
REQ-009 The counter outputs SHALL be: cnt_alui, cnt_load, cnt_store, cnt_illegal  output  CNT_W each  count of accepted instructions per class.

Function
REQ-010 Accept SHALL occur when in_valid and in_ready are both 1; pop SHALL occur when out_valid and out_ready are both 1.
REQ-011 The buffer SHALL be a 2-entry FIFO holding decoded entries; in_ready SHALL equal not-full, and out_valid SHALL equal not-empty.
REQ-012 Latency SHALL be one cycle: an instruction accepted at edge N SHALL be visible on out_* after edge N, with no combinational in-to-out path.
REQ-013 A simultaneous accept and pop SHALL keep the occupancy unchanged and preserve order; when full, in_ready SHALL be 0 even if out_ready is 1.
REQ-014 Opcode 0010011 SHALL decode as ALUI: rd, rs1, funct3 taken from the instruction; out_rs2=0.
REQ-015 For ALUI with funct3 other than 1 or 5, out_imm SHALL be instr[31:20] sign-extended.
REQ-016 For ALUI with funct3 1 or 5, out_imm SHALL be zero-extended instr[24:20].
REQ-017 ALUI SHALL be ILLEGAL when funct3=1 and instr[31:25]!=0, or when funct3=5 and instr[31:25] is neither 0x00 nor 0x20.
REQ-018 Opcode 0000011 SHALL decode as LOAD: out_imm = instr[31:20] sign-extended; out_rs2=0; funct3 not in {0,1,2,4,5} SHALL make it ILLEGAL.
REQ-019 Opcode 0100011 SHALL decode as STORE: out_imm = {instr[31:25],instr[11:7]} sign-extended; out_rd=0; funct3 not in {0,1,2} SHALL make it ILLEGAL.
REQ-020 Any other opcode SHALL decode as ILLEGAL; ILLEGAL entries SHALL carry out_rd, out_rs1, out_rs2, out_funct3, out_imm and out_load_use all 0.
REQ-021 A last-load register (valid bit + 5-bit rd) SHALL update on every accept: set to rd for a legal LOAD with rd!=0, cleared otherwise.
REQ-022 out_load_use SHALL be 1 when last-load is valid and (ALUI or LOAD with rs1==last rd) or (STORE with rs1 or rs2 == last rd), evaluated against last-load state before the update of the same accept.
REQ-023 On each accept, exactly one counter SHALL increment; each counter SHALL saturate at all-ones and never wrap.
REQ-024 Counters SHALL count accepts regardless of downstream pops.

Reset
REQ-025 While reset_n=0 at a rising edge, the FIFO SHALL be emptied, last-load cleared and all counters zeroed, so that afterwards out_valid=0, in_ready=1 and out_* data=0.
REQ-026 Reset SHALL override a simultaneous accept or pop in the same cycle; entries in flight SHALL be discarded.

Verification
REQ-027 Accepting 0x00000013 SHALL give, next cycle, out_valid=1, class=0, rd=rs1=0, imm=0, load_use=0, cnt_alui=1.
REQ-028 Accepting 0x00402283 (lw x5,4(x0)) and then 0x00128313 (addi x6,x5,1) SHALL give a second entry with class=0, rs1=5, load_use=1; inserting 0x00000013 between them SHALL give load_use=0.
REQ-029 Accepting 0xFE20AE23 (sw x2,-4(x1)) SHALL give class=2, rs1=1, rs2=2, funct3=2, rd=0, imm=0xFFFFFFFC, cnt_store=1.
REQ-030 Accepting 0x04001013 (slli with nonzero funct7) and 0x0000007F SHALL give class=3 with all fields 0 and cnt_illegal=2.
REQ-031 With out_ready=0 and 3 instructions offered back-to-back, exactly 2 SHALL be accepted and in_ready SHALL fall after the second; raising out_ready SHALL drain them in order, then accept the third.
REQ-032 With CNT_W=2 and 5 ALUI accepts, cnt_alui SHALL read 3; asserting reset_n=0 with 2 entries buffered SHALL give out_valid=0 and all counters 0 after the edge.

Source files
------------

// File: rtl/ils_decode_monitor.sv
// ils_decode_monitor
//
// Decodes RV32 ALU-immediate, LOAD and STORE instruction words into a compact
// entry and queues each entry in a two-entry FIFO. Every entry is flagged when
// it reads the destination register of the load accepted just before it. The
// block also keeps a saturating count of accepted instructions per class.
//
// Parameters:
//   CNT_W        width of each class counter
//
// Ports:
//   clk          sole clock, rising-edge active
//   reset_n      synchronous active-low reset
//   in_valid     upstream offers in_instr this cycle
//   in_instr     RV32 instruction word
//   in_ready     block can accept an instruction this cycle (FIFO not full)
//   out_ready    consumer accepts the head entry
//   out_valid    head entry valid (FIFO not empty)
//   out_class    0=ALUI, 1=LOAD, 2=STORE, 3=ILLEGAL
//   out_rd/rs1/rs2, out_funct3, out_imm   decoded fields of the head entry
//   out_load_use head entry reads the rd of the immediately preceding load
//   cnt_alui/cnt_load/cnt_store/cnt_illegal  saturating per-class accept counts

module ils_decode_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [1:0]       out_class,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [31:0]      out_imm,
    output logic             out_load_use,
    output logic [CNT_W-1:0] cnt_alui,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam logic [1:0] CLASS_ALUI    = 2'd0;
    localparam logic [1:0] CLASS_LOAD    = 2'd1;
    localparam logic [1:0] CLASS_STORE   = 2'd2;
    localparam logic [1:0] CLASS_ILLEGAL = 2'd3;

    localparam logic [6:0] OPC_ALUI  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic        load_use;
    } entry_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // Raw instruction fields
    logic [6:0] opcode_s;
    logic [4:0] rd_field_s;
    logic [2:0] funct3_s;
    logic [4:0] rs1_field_s;
    logic [4:0] rs2_field_s;
    logic [6:0] funct7_s;

    assign opcode_s    = in_instr[6:0];
    assign rd_field_s  = in_instr[11:7];
    assign funct3_s    = in_instr[14:12];
    assign rs1_field_s = in_instr[19:15];
    assign rs2_field_s = in_instr[24:20];
    assign funct7_s    = in_instr[31:25];

    // FIFO and tracking state
    entry_t           mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             last_valid_r;
    logic [4:0]       last_rd_r;
    logic [CNT_W-1:0] cnt_alui_r;
    logic [CNT_W-1:0] cnt_load_r;
    logic [CNT_W-1:0] cnt_store_r;
    logic [CNT_W-1:0] cnt_illegal_r;

    entry_t dec_s;
    entry_t head_s;
    logic   accept_s;
    logic   pop_s;

    assign in_ready  = (count_r != OCC_FULL);
    assign out_valid = (count_r != OCC_EMPTY);
    assign accept_s  = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Decode the offered word into an entry; illegal words leave every field zero.
    always_comb begin
        dec_s     = '0;
        dec_s.cls = CLASS_ILLEGAL;
        case (opcode_s)
            OPC_ALUI: begin
                // Shift-immediates reserve funct7; only SRAI may use 0x20.
                if ((funct3_s == 3'd1) && (funct7_s != 7'h00)) begin
                    dec_s.cls = CLASS_ILLEGAL;
                end else if ((funct3_s == 3'd5) && (funct7_s != 7'h00) && (funct7_s != 7'h20)) begin
                    dec_s.cls = CLASS_ILLEGAL;
                end else begin
                    dec_s.cls    = CLASS_ALUI;
                    dec_s.rd     = rd_field_s;
                    dec_s.rs1    = rs1_field_s;
                    dec_s.funct3 = funct3_s;
                    if ((funct3_s == 3'd1) || (funct3_s == 3'd5)) begin
                        dec_s.imm = {27'd0, in_instr[24:20]};
                    end else begin
                        dec_s.imm = {{20{in_instr[31]}}, in_instr[31:20]};
                    end
                end
            end
            OPC_LOAD: begin
                case (funct3_s)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: begin
                        dec_s.cls    = CLASS_LOAD;
                        dec_s.rd     = rd_field_s;
                        dec_s.rs1    = rs1_field_s;
                        dec_s.funct3 = funct3_s;
                        dec_s.imm    = {{20{in_instr[31]}}, in_instr[31:20]};
                    end
                    default: begin
                        dec_s.cls = CLASS_ILLEGAL;
                    end
                endcase
            end
            OPC_STORE: begin
                case (funct3_s)
                    3'd0, 3'd1, 3'd2: begin
                        dec_s.cls    = CLASS_STORE;
                        dec_s.rs1    = rs1_field_s;
                        dec_s.rs2    = rs2_field_s;
                        dec_s.funct3 = funct3_s;
                        dec_s.imm    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                    end
                    default: begin
                        dec_s.cls = CLASS_ILLEGAL;
                    end
                endcase
            end
            default: begin
                dec_s.cls = CLASS_ILLEGAL;
            end
        endcase

        // Hazard check uses the last-load state before this accept updates it.
        // last_rd_r is never x0, so zeroed source fields cannot match.
        if (!last_valid_r) begin
            dec_s.load_use = 1'b0;
        end else begin
            case (dec_s.cls)
                CLASS_ALUI, CLASS_LOAD: dec_s.load_use = (dec_s.rs1 == last_rd_r);
                CLASS_STORE:            dec_s.load_use = (dec_s.rs1 == last_rd_r) ||
                                                         (dec_s.rs2 == last_rd_r);
                default:                dec_s.load_use = 1'b0;
            endcase
        end
    end

    // Head of the FIFO drives the outputs directly from storage registers.
    assign head_s       = mem_r[rd_ptr_r];
    assign out_class    = head_s.cls;
    assign out_rd       = head_s.rd;
    assign out_rs1      = head_s.rs1;
    assign out_rs2      = head_s.rs2;
    assign out_funct3   = head_s.funct3;
    assign out_imm      = head_s.imm;
    assign out_load_use = head_s.load_use;

    assign cnt_alui    = cnt_alui_r;
    assign cnt_load    = cnt_load_r;
    assign cnt_store   = cnt_store_r;
    assign cnt_illegal = cnt_illegal_r;

    // Two-entry FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= OCC_EMPTY;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= dec_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + OCC_ONE;
                2'b01:   count_r <= count_r - OCC_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Last-load tracker: refreshed on every accept, set only by a legal load to a real register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_valid_r <= 1'b0;
            last_rd_r    <= 5'd0;
        end else if (accept_s) begin
            if ((dec_s.cls == CLASS_LOAD) && (dec_s.rd != 5'd0)) begin
                last_valid_r <= 1'b1;
                last_rd_r    <= dec_s.rd;
            end else begin
                last_valid_r <= 1'b0;
                last_rd_r    <= 5'd0;
            end
        end else begin
            last_valid_r <= last_valid_r;
            last_rd_r    <= last_rd_r;
        end
    end

    // Per-class accept counters; pops have no effect on them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_alui_r    <= '0;
            cnt_load_r    <= '0;
            cnt_store_r   <= '0;
            cnt_illegal_r <= '0;
        end else if (accept_s) begin
            case (dec_s.cls)
                CLASS_ALUI:  cnt_alui_r    <= sat_inc(cnt_alui_r);
                CLASS_LOAD:  cnt_load_r    <= sat_inc(cnt_load_r);
                CLASS_STORE: cnt_store_r   <= sat_inc(cnt_store_r);
                default:     cnt_illegal_r <= sat_inc(cnt_illegal_r);
            endcase
        end else begin
            cnt_alui_r    <= cnt_alui_r;
            cnt_load_r    <= cnt_load_r;
            cnt_store_r   <= cnt_store_r;
            cnt_illegal_r <= cnt_illegal_r;
        end
    end

endmodule

// File: tb/tb_ils_decode_monitor.sv
// Self-checking bench for ils_decode_monitor: a table of instruction words with
// hand-decoded expected entries, applied back to back, followed by hand-written
// sequences for backpressure, counter saturation (CNT_W=2) and reset.

module tb_ils_decode_monitor;

    logic        clk;
    logic        reset_n;
    logic        reset_n2;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid, out_load_use;
    logic [1:0]  out_class;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [31:0] out_imm;
    logic [15:0] cnt_alui, cnt_load, cnt_store, cnt_illegal;

    logic        in_ready2, out_valid2, out_load_use2;
    logic [1:0]  out_class2;
    logic [4:0]  out_rd2, out_rs12, out_rs22;
    logic [2:0]  out_funct32;
    logic [31:0] out_imm2;
    logic [1:0]  cnt2_alui, cnt2_load, cnt2_store, cnt2_illegal;

    ils_decode_monitor #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_imm(out_imm), .out_load_use(out_load_use),
        .cnt_alui(cnt_alui), .cnt_load(cnt_load), .cnt_store(cnt_store),
        .cnt_illegal(cnt_illegal)
    );

    ils_decode_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n2), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready2), .out_ready(out_ready), .out_valid(out_valid2),
        .out_class(out_class2), .out_rd(out_rd2), .out_rs1(out_rs12), .out_rs2(out_rs22),
        .out_funct3(out_funct32), .out_imm(out_imm2), .out_load_use(out_load_use2),
        .cnt_alui(cnt2_alui), .cnt_load(cnt2_load), .cnt_store(cnt2_store),
        .cnt_illegal(cnt2_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic        lu;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    int pass_cnt;
    int total_cnt;
    int exp_cnt [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, " cnt_alui"},    32'(cnt_alui),    32'(exp_cnt[0]));
        check({tag, " cnt_load"},    32'(cnt_load),    32'(exp_cnt[1]));
        check({tag, " cnt_store"},   32'(cnt_store),   32'(exp_cnt[2]));
        check({tag, " cnt_illegal"}, 32'(cnt_illegal), 32'(exp_cnt[3]));
    endtask

    initial begin
        string tag;
        pass_cnt  = 0;
        total_cnt = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        //            instr         cls   rd    rs1   rs2   f3    imm            lu
        vecs[0]  = '{32'h00000013, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0}; // nop
        vecs[1]  = '{32'h00402283, 2'd1, 5'd5, 5'd0, 5'd0, 3'd2, 32'h00000004, 1'b0}; // lw x5,4(x0)
        vecs[2]  = '{32'h00128313, 2'd0, 5'd6, 5'd5, 5'd0, 3'd0, 32'h00000001, 1'b1}; // addi x6,x5,1
        vecs[3]  = '{32'h00402283, 2'd1, 5'd5, 5'd0, 5'd0, 3'd2, 32'h00000004, 1'b0};
        vecs[4]  = '{32'h00000013, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0};
        vecs[5]  = '{32'h00128313, 2'd0, 5'd6, 5'd5, 5'd0, 3'd0, 32'h00000001, 1'b0}; // nop in between
        vecs[6]  = '{32'hFE20AE23, 2'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFFFFFC, 1'b0}; // sw x2,-4(x1)
        vecs[7]  = '{32'h00002103, 2'd1, 5'd2, 5'd0, 5'd0, 3'd2, 32'h00000000, 1'b0}; // lw x2,0(x0)
        vecs[8]  = '{32'hFE20AE23, 2'd2, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFFFFFC, 1'b1}; // store rs2 hazard
        vecs[9]  = '{32'h04001013, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0}; // slli bad funct7
        vecs[10] = '{32'h0000007F, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0}; // bad opcode
        vecs[11] = '{32'h00501093, 2'd0, 5'd1, 5'd0, 5'd0, 3'd1, 32'h00000005, 1'b0}; // slli x1,x0,5
        vecs[12] = '{32'h41F0D093, 2'd0, 5'd1, 5'd1, 5'd0, 3'd5, 32'h0000001F, 1'b0}; // srai x1,x1,31
        vecs[13] = '{32'h2000D093, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0}; // srli funct7=0x10
        vecs[14] = '{32'hFFF20193, 2'd0, 5'd3, 5'd4, 5'd0, 3'd0, 32'hFFFFFFFF, 1'b0}; // addi x3,x4,-1
        vecs[15] = '{32'h00003283, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0}; // load funct3=3
        vecs[16] = '{32'h00128313, 2'd0, 5'd6, 5'd5, 5'd0, 3'd0, 32'h00000001, 1'b0};
        vecs[17] = '{32'h0000A003, 2'd1, 5'd0, 5'd1, 5'd0, 3'd2, 32'h00000000, 1'b0}; // lw x0,0(x1)
        vecs[18] = '{32'h00000013, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0}; // x0 never hazards
        vecs[19] = '{32'h80040383, 2'd1, 5'd7, 5'd8, 5'd0, 3'd0, 32'hFFFFF800, 1'b0}; // lb x7,-2048(x8)
        vecs[20] = '{32'h0003A023, 2'd2, 5'd0, 5'd7, 5'd0, 3'd2, 32'h00000000, 1'b1}; // sw x0,0(x7)
        vecs[21] = '{32'h00003023, 2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 1'b0}; // store funct3=3

        // Reset state
        reset_n   = 1'b0;
        reset_n2  = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_class", 32'(out_class), 32'd0);
        check("reset out_imm",   out_imm,        32'd0);
        check("reset out_rd",    32'(out_rd),    32'd0);
        check_counters("reset");
        reset_n = 1'b1;

        // Table: one accept per cycle with out_ready=1, so each entry is the head one cycle later
        for (int i = 0; i < NVEC; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            exp_cnt[vecs[i].cls]++;
            @(negedge clk);
            tag = $sformatf("vec%0d", i);
            check({tag, " out_valid"}, 32'(out_valid),    32'd1);
            check({tag, " class"},     32'(out_class),    32'(vecs[i].cls));
            check({tag, " rd"},        32'(out_rd),       32'(vecs[i].rd));
            check({tag, " rs1"},       32'(out_rs1),      32'(vecs[i].rs1));
            check({tag, " rs2"},       32'(out_rs2),      32'(vecs[i].rs2));
            check({tag, " funct3"},    32'(out_funct3),   32'(vecs[i].f3));
            check({tag, " imm"},       out_imm,           vecs[i].imm);
            check({tag, " load_use"},  32'(out_load_use), 32'(vecs[i].lu));
            check_counters(tag);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("drain out_valid", 32'(out_valid), 32'd0);
        check_counters("drain");

        // Backpressure: three offers with out_ready=0, only two fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;                   // addi x1,x0,1
        @(negedge clk);
        check("bp in_ready after 1", 32'(in_ready), 32'd1);
        in_instr = 32'h00200113;                    // addi x2,x0,2
        @(negedge clk);
        check("bp in_ready after 2", 32'(in_ready), 32'd0);
        check("bp head rd A",        32'(out_rd),   32'd1);
        in_instr = 32'h00300193;                    // addi x3,x0,3
        @(negedge clk);
        check("bp in_ready held",    32'(in_ready), 32'd0);
        check("bp head still A",     32'(out_rd),   32'd1);
        exp_cnt[0] += 2;
        check("bp cnt_alui 2 only",  32'(cnt_alui), 32'(exp_cnt[0]));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp head B",           32'(out_rd),   32'd2);
        check("bp in_ready reopened", 32'(in_ready), 32'd1);
        check("bp cnt after pop",    32'(cnt_alui), 32'(exp_cnt[0]));
        @(negedge clk);
        exp_cnt[0] += 1;
        in_valid = 1'b0;
        check("bp head C",           32'(out_rd),   32'd3);
        check("bp out_valid C",      32'(out_valid), 32'd1);
        check("bp cnt third",        32'(cnt_alui), 32'(exp_cnt[0]));
        @(negedge clk);
        check("bp empty",            32'(out_valid), 32'd0);

        // Saturation on the CNT_W=2 instance
        reset_n2  = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("sat cnt2_alui %0d", i + 1), 32'(cnt2_alui),
                  (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check("sat cnt2_load", 32'(cnt2_load), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // Reset with two entries buffered, overriding a simultaneous accept and pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00402283;
        @(negedge clk);
        in_instr = 32'hFE20AE23;
        @(negedge clk);
        check("rst pre out_valid", 32'(out_valid), 32'd1);
        check("rst pre in_ready",  32'(in_ready),  32'd0);
        reset_n   = 1'b0;
        reset_n2  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        check("rst out_valid",    32'(out_valid),    32'd0);
        check("rst in_ready",     32'(in_ready),     32'd1);
        check("rst out_class",    32'(out_class),    32'd0);
        check("rst out_imm",      out_imm,           32'd0);
        check("rst out_rs1",      32'(out_rs1),      32'd0);
        check("rst out_load_use", 32'(out_load_use), 32'd0);
        check_counters("rst");
        check("rst cnt2_alui",    32'(cnt2_alui),    32'd0);
        check("rst out_valid2",   32'(out_valid2),   32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        // Last-load must have been cleared by reset: addi x6,x5,1 shows no hazard
        in_valid = 1'b1;
        in_instr = 32'h00128313;
        @(negedge clk);
        in_valid = 1'b0;
        check("post-rst load_use", 32'(out_load_use), 32'd0);
        check("post-rst cnt_alui", 32'(cnt_alui),     32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
